// File: rtl/llc_mem_adapter_pkg.sv
// Shared constants and types for the LLC memory-bus adapter.
// Defaults describe a 32-byte line carried as four 64-bit beats.
package llc_mem_adapter_pkg;

    localparam int LLC_WORDS_PER_LINE = 4;
    localparam int LLC_BITS_PER_WORD  = 64;
    localparam int LLC_ADDR_BITS      = 32;
    localparam int LLC_LADDR_BITS     = 26;

    localparam int LLC_IDX_BITS      = $clog2(LLC_WORDS_PER_LINE);
    localparam int LLC_WORD_OFF_BITS = $clog2(LLC_BITS_PER_WORD / 8);
    localparam int LLC_LINE_OFF_BITS = LLC_IDX_BITS + LLC_WORD_OFF_BITS;

    typedef logic [LLC_WORDS_PER_LINE*LLC_BITS_PER_WORD-1:0] line_t;
    typedef logic [LLC_LADDR_BITS-1:0]                      line_addr_t;
    typedef logic [LLC_LINE_OFF_BITS-1:0]                   line_off_t;

    typedef struct packed {
        logic [LLC_BITS_PER_WORD-1:0] data;
        logic                         last;
    } mem_beat_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_WRESP = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_RSP   = 3'd5;

endpackage

// File: rtl/llc_mem_line_buf.sv
// Line buffer for the memory adapter: whole-line load, and one word
// written or read per beat at the beat index.
module llc_mem_line_buf
    import llc_mem_adapter_pkg::*;
#(
    parameter int  WORDS     = LLC_WORDS_PER_LINE,
    parameter int  WORD_BITS = LLC_BITS_PER_WORD,
    localparam int IW        = $clog2(WORDS),
    localparam int LW        = WORDS * WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [LW-1:0]        line_i,
    input  logic                 wr_i,
    input  logic [IW-1:0]        idx_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    output logic [WORD_BITS-1:0] rdata_o,
    output logic [LW-1:0]        line_o
);

    logic [WORD_BITS-1:0] mem_q [WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= line_i[i*WORD_BITS +: WORD_BITS];
            end
        end else if (wr_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

    always_comb begin
        line_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            line_o[i*WORD_BITS +: WORD_BITS] = mem_q[i];
        end
    end

endmodule

// File: rtl/llc_mem_adapter.sv
// LLC memory adapter: serializes line requests into word bursts on
// the split address/write/read bus and reassembles fill lines.
module llc_mem_adapter
    import llc_mem_adapter_pkg::*;
#(
    parameter int  WORDS_PER_LINE = LLC_WORDS_PER_LINE,
    parameter int  WORD_BITS      = LLC_BITS_PER_WORD,
    parameter int  ADDR_BITS      = LLC_ADDR_BITS,
    parameter int  LADDR_BITS     = LLC_LADDR_BITS,
    localparam int LINE_BITS      = WORDS_PER_LINE * WORD_BITS
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_hwrite,
    input  logic [1:0]            req_hprot,
    input  logic [LADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0]  req_line,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [LINE_BITS-1:0]  rsp_line,

    output logic                  bus_aw_valid,
    input  logic                  bus_aw_ready,
    output logic                  bus_aw_write,
    output logic [ADDR_BITS-1:0]  bus_aw_addr,
    output logic [1:0]            bus_aw_prot,

    output logic                  bus_w_valid,
    input  logic                  bus_w_ready,
    output logic [WORD_BITS-1:0]  bus_w_data,
    output logic                  bus_w_last,

    input  logic                  bus_b_valid,
    output logic                  bus_b_ready,

    input  logic                  bus_r_valid,
    output logic                  bus_r_ready,
    input  logic [WORD_BITS-1:0]  bus_r_data,
    input  logic                  bus_r_last,

    output logic                  err_burst
);

    localparam int CW  = $clog2(WORDS_PER_LINE);
    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_LINE - 1);

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [1:0]            prot_q, prot_d;
    logic [LADDR_BITS-1:0] addr_q, addr_d;

    logic                  buf_load;
    logic                  buf_wr;
    logic [WORD_BITS-1:0]  buf_word;
    logic [LINE_BITS-1:0]  buf_line;
    logic                  last_beat;

    logic in_idle, in_addr, in_wdata, in_wresp, in_rdata, in_rsp;

    logic [LADDR_BITS+OFF-1:0] byte_addr;

    llc_mem_line_buf #(
        .WORDS     (WORDS_PER_LINE),
        .WORD_BITS (WORD_BITS)
    ) u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .line_i  (req_line),
        .wr_i    (buf_wr),
        .idx_i   (cnt_q),
        .wdata_i (bus_r_data),
        .rdata_o (buf_word),
        .line_o  (buf_line)
    );

    assign last_beat = (cnt_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        prot_d   = prot_q;
        addr_d   = addr_q;
        buf_load = 1'b0;
        buf_wr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_hwrite;
                    prot_d   = req_hprot;
                    addr_d   = req_addr;
                    buf_load = 1'b1;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_aw_ready) begin
                    cnt_d   = '0;
                    state_d = write_q ? ST_WDATA : ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (bus_w_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (bus_b_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                // Beat count alone ends the burst; r_last only flags errors.
                if (bus_r_valid) begin
                    buf_wr = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = ST_RSP;
                    end
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            prot_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            prot_q  <= prot_d;
            addr_q  <= addr_d;
        end
    end

    // Qualify with rst so every handshake output drops the moment reset hits.
    assign in_idle  = rst && (state_q == ST_IDLE);
    assign in_addr  = rst && (state_q == ST_ADDR);
    assign in_wdata = rst && (state_q == ST_WDATA);
    assign in_wresp = rst && (state_q == ST_WRESP);
    assign in_rdata = rst && (state_q == ST_RDATA);
    assign in_rsp   = rst && (state_q == ST_RSP);

    assign byte_addr = {addr_q, {OFF{1'b0}}};

    assign req_ready    = in_idle;
    assign rsp_valid    = in_rsp;
    assign rsp_line     = buf_line;

    assign bus_aw_valid = in_addr;
    assign bus_aw_write = write_q;
    assign bus_aw_addr  = ADDR_BITS'(byte_addr);
    assign bus_aw_prot  = prot_q;

    assign bus_w_valid  = in_wdata;
    assign bus_w_data   = buf_word;
    assign bus_w_last   = in_wdata && last_beat;

    assign bus_b_ready  = in_wresp;
    assign bus_r_ready  = in_rdata;

    assign err_burst = in_rdata && bus_r_valid && (bus_r_last != last_beat);

endmodule

// File: tb/tb_llc_mem_adapter.sv
// Self-checking bench for llc_mem_adapter: a bus responder plus a
// transaction-level model of the expected beats, lines and addresses.
module tb_llc_mem_adapter;

    localparam int N   = 4;
    localparam int WB  = 64;
    localparam int AB  = 32;
    localparam int LAB = 26;
    localparam int LW  = N * WB;
    localparam int LINE_BYTES = LW / 8;
    localparam int TMO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid, req_ready, req_hwrite;
    logic [1:0]     req_hprot;
    logic [LAB-1:0] req_addr;
    logic [LW-1:0]  req_line;
    logic           rsp_valid, rsp_ready;
    logic [LW-1:0]  rsp_line;
    logic           bus_aw_valid, bus_aw_ready, bus_aw_write;
    logic [AB-1:0]  bus_aw_addr;
    logic [1:0]     bus_aw_prot;
    logic           bus_w_valid, bus_w_ready, bus_w_last;
    logic [WB-1:0]  bus_w_data;
    logic           bus_b_valid, bus_b_ready;
    logic           bus_r_valid, bus_r_ready, bus_r_last;
    logic [WB-1:0]  bus_r_data;
    logic           err_burst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    llc_mem_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_hwrite   (req_hwrite),
        .req_hprot    (req_hprot),
        .req_addr     (req_addr),
        .req_line     (req_line),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_line     (rsp_line),
        .bus_aw_valid (bus_aw_valid),
        .bus_aw_ready (bus_aw_ready),
        .bus_aw_write (bus_aw_write),
        .bus_aw_addr  (bus_aw_addr),
        .bus_aw_prot  (bus_aw_prot),
        .bus_w_valid  (bus_w_valid),
        .bus_w_ready  (bus_w_ready),
        .bus_w_data   (bus_w_data),
        .bus_w_last   (bus_w_last),
        .bus_b_valid  (bus_b_valid),
        .bus_b_ready  (bus_b_ready),
        .bus_r_valid  (bus_r_valid),
        .bus_r_ready  (bus_r_ready),
        .bus_r_data   (bus_r_data),
        .bus_r_last   (bus_r_last),
        .err_burst    (err_burst)
    );

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    function automatic logic [511:0] all_outs();
        return 512'({req_ready, rsp_valid, rsp_line, bus_aw_valid,
                     bus_aw_write, bus_aw_addr, bus_aw_prot, bus_w_valid,
                     bus_w_data, bus_w_last, bus_b_ready, bus_r_ready,
                     err_burst});
    endfunction

    task automatic drive_idle();
        req_valid    = 1'b0;
        req_hwrite   = 1'b0;
        req_hprot    = '0;
        req_addr     = '0;
        req_line     = '0;
        rsp_ready    = 1'b0;
        bus_aw_ready = 1'b0;
        bus_w_ready  = 1'b0;
        bus_b_valid  = 1'b0;
        bus_r_valid  = 1'b0;
        bus_r_data   = '0;
        bus_r_last   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a falling edge; returns at the same point.
    // ln is the writeback line or the data the bus returns for a fill.
    task automatic run_txn(input bit wr, input logic [LAB-1:0] a,
                           input logic [1:0] p, input logic [LW-1:0] ln,
                           input int mode, input int bad_last,
                           input int rsp_stall, input bit hold_next,
                           input int abort_beat);
        logic [AB-1:0] exp_addr;
        logic          hs;
        logic          lastf;
        int            cyc;
        int            wc;

        exp_addr = AB'(a) * AB'(LINE_BYTES);

        req_valid  = 1'b1;
        req_hwrite = wr;
        req_hprot  = p;
        req_addr   = a;
        req_line   = wr ? ln : rand_line();
        #1;
        check("req_ready_idle", 512'(req_ready), 512'(1));
        check("aw_not_comb", 512'(bus_aw_valid), 512'(0));
        step();
        req_valid = 1'b0;
        req_line  = rand_line();
        req_addr  = LAB'($urandom);

        cyc = 0;
        hs  = 1'b0;
        while (!hs && cyc < TMO) begin
            bus_aw_ready = rdy(mode, cyc);
            #1;
            check("aw_valid", 512'(bus_aw_valid), 512'(1));
            check("aw_addr", 512'(bus_aw_addr), 512'(exp_addr));
            check("aw_write", 512'(bus_aw_write), 512'(wr));
            check("aw_prot", 512'(bus_aw_prot), 512'(p));
            hs = bus_aw_ready;
            step();
            bus_aw_ready = 1'b0;
            cyc++;
        end
        if (!hs) begin
            check("aw_timeout", 512'(0), 512'(1));
            return;
        end

        if (wr) begin
            wc = 0;
            for (int k = 0; k < N; k++) begin
                if (k == abort_beat) begin
                    rst = 1'b0;
                    #1;
                    check("rst_mid_outs", all_outs(), 512'(0));
                    return;
                end
                cyc = 0;
                hs  = 1'b0;
                while (!hs && cyc < TMO) begin
                    bus_w_ready = rdy(mode, wc);
                    #1;
                    check("w_valid", 512'(bus_w_valid), 512'(1));
                    check("w_data", 512'(bus_w_data), 512'(ln[k*WB +: WB]));
                    check("w_last", 512'(bus_w_last), 512'(k == N - 1));
                    hs = bus_w_ready;
                    step();
                    bus_w_ready = 1'b0;
                    cyc++;
                    wc++;
                end
                if (!hs) begin
                    check("w_timeout", 512'(0), 512'(1));
                    return;
                end
            end
            cyc = (mode == 0) ? 0 : $urandom_range(0, 3);
            for (int i = 0; i <= cyc; i++) begin
                bus_b_valid = (i == cyc);
                req_valid   = hold_next;
                #1;
                check("b_ready", 512'(bus_b_ready), 512'(1));
                check("no_rsp_on_wr", 512'(rsp_valid), 512'(0));
                check("req_ready_busy", 512'(req_ready), 512'(0));
                step();
            end
            bus_b_valid = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                lastf = (bad_last < 0) ? (k == N - 1) : (k == bad_last);
                cyc = 0;
                hs  = 1'b0;
                while (!hs && cyc < TMO) begin
                    bus_r_valid = rdy(mode, cyc);
                    bus_r_data  = bus_r_valid ? ln[k*WB +: WB] : WB'($urandom);
                    bus_r_last  = bus_r_valid ? lastf : 1'($urandom);
                    #1;
                    check("r_ready", 512'(bus_r_ready), 512'(1));
                    check("err_burst", 512'(err_burst),
                          512'(bus_r_valid && (lastf != (k == N - 1))));
                    check("rsp_early", 512'(rsp_valid), 512'(0));
                    hs = bus_r_valid;
                    step();
                    cyc++;
                end
                bus_r_valid = 1'b0;
                bus_r_last  = 1'b0;
                if (!hs) begin
                    check("r_timeout", 512'(0), 512'(1));
                    return;
                end
            end
            for (int c = 0; c <= rsp_stall; c++) begin
                rsp_ready = (c == rsp_stall);
                req_valid = hold_next;
                #1;
                check("rsp_valid", 512'(rsp_valid), 512'(1));
                check("rsp_line", 512'(rsp_line), 512'(ln));
                check("req_ready_busy", 512'(req_ready), 512'(0));
                step();
            end
            rsp_ready = 1'b0;
        end
        #1;
        check("req_ready_back", 512'(req_ready), 512'(1));
        check("rsp_after", 512'(rsp_valid), 512'(0));
    endtask

    initial begin
        logic [LW-1:0] ln;
        logic          wr;
        int            bad;

        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", all_outs(), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_reset_ready", 512'(req_ready), 512'(1));

        ln = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
              64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
        run_txn(1'b0, 26'h0000123, 2'b01, ln, 0, -1, 0, 1'b0, -1);
        check("aw_addr_0x123", 512'(AB'(26'h0000123) * 32), 512'(32'h2460));

        ln = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        run_txn(1'b1, 26'h0000040, 2'b10, ln, 1, -1, 0, 1'b0, -1);

        run_txn(1'b0, LAB'($urandom), 2'($urandom), rand_line(),
                0, -1, 5, 1'b0, -1);

        run_txn(1'b0, LAB'($urandom), 2'($urandom), rand_line(),
                0, 1, 0, 1'b0, -1);

        run_txn(1'b1, LAB'($urandom), 2'($urandom), rand_line(),
                0, -1, 0, 1'b0, 2);
        drive_idle();
        repeat (2) step();
        #1;
        check("rst_held_outs", all_outs(), 512'(0));
        @(negedge clk);
        rst = 1'b1;
        run_txn(1'b0, LAB'($urandom), 2'($urandom), rand_line(),
                0, -1, 0, 1'b0, -1);

        run_txn(1'b0, LAB'($urandom), 2'($urandom), rand_line(),
                0, -1, 2, 1'b1, -1);
        run_txn(1'b1, LAB'($urandom), 2'($urandom), rand_line(),
                0, -1, 0, 1'b0, -1);

        for (int t = 0; t < 24; t++) begin
            wr  = 1'($urandom);
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : -1;
            run_txn(wr, LAB'($urandom), 2'($urandom), rand_line(),
                    2, bad, $urandom_range(0, 3), 1'($urandom), -1);
        end
        req_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
